// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes two requesters (req/we/addr/wdata in, ack/rdata out per port) onto one memory port (mem_rd/mem_wr/mem_addr/mem_wdata out, mem_rdata in) with busy and gnt_id status; async active-low init; define ROUND_ROBIN_EN for round-robin ties, else port 0 has fixed priority
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          init,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic win, acc, g_we;
`ifdef ROUND_ROBIN_EN
  logic last;
  assign win = (req0 & req1) ? ~last : ~req0;
`else
  assign win = ~req0;
`endif
  assign acc = state == ACCESS;
  assign g_we = gnt_id ? we1 : we0;
  assign busy = state != IDLE;
  assign mem_rd = acc & ~g_we;
  assign mem_wr = acc & g_we;
  assign mem_addr = acc ? (gnt_id ? addr1 : addr0) : '0;
  assign mem_wdata = acc ? (gnt_id ? wdata1 : wdata0) : '0;
  always_ff @(posedge clk or negedge init)
    if (!init) begin
      state <= IDLE;
      cnt <= '0;
      gnt_id <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
`ifdef ROUND_ROBIN_EN
      last <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          gnt_id <= win;
          cnt <= 4'(MEM_LAT - 1);
          state <= ACCESS;
`ifdef ROUND_ROBIN_EN
          last <= win;
`endif
        end
        ACCESS: if (cnt == '0) begin
          if (!g_we && !gnt_id) rdata0 <= mem_rdata;
          if (!g_we && gnt_id) rdata1 <= mem_rdata;
          ack0 <= ~gnt_id;
          ack1 <= gnt_id;
          state <= RESP;
        end else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int L = 2;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, init = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, mem_rd, mem_wr, busy, gnt_id;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic b_req0 = 1'b0;
  logic [31:0] b_addr0 = '0;
  logic b_ack0, b_ack1, b_rd, b_wr, b_busy, b_gnt;
  logic [31:0] b_rdata0, b_rdata1, b_addr, b_wdata, b_rdata;
  int total = 0, bad = 0, wr_cyc = 0, ack0_cnt = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) dut (
    .clk(clk), .init(init), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .init(init), .req0(b_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(b_addr0), .addr1(32'h0), .wdata0(32'h1111_2222), .wdata1(32'h0),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .mem_rd(b_rd), .mem_wr(b_wr), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_rdata(b_rdata), .busy(b_busy), .gnt_id(b_gnt)
  );
  assign mem_rdata = mem[mem_addr[7:0]];
  assign b_rdata = 32'hA5A5_0000 | {24'h0, b_addr[7:0]};
  always @(posedge clk) if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 32'hC000_0000 | 32'(i);
      ref_mem[i] <= 32'hC000_0000 | 32'(i);
    end
    mem[8'h10] <= 32'hDEADBEEF;
    ref_mem[8'h10] <= 32'hDEADBEEF;
  end
  // transaction model: an access granted at an edge occupies L strobe cycles, then one ack cycle
  logic m_act, m_g, m_we, m_last, pick, e_acc, e_ack;
  int m_age;
  logic [31:0] m_addr, m_wdata, m_rd0, m_rd1;
  assign pick = (req0 && req1) ? (RR && !m_last) : req1;
  assign e_acc = m_act && m_age <= L;
  assign e_ack = m_act && m_age == L + 1;
  always @(posedge clk or negedge init)
    if (!init) begin
      m_act <= 1'b0;
      m_age <= 0;
      m_g <= 1'b0;
      m_last <= 1'b1;
      m_we <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      m_rd0 <= '0;
      m_rd1 <= '0;
    end else if (m_act) begin
      m_age <= m_age + 1;
      if (m_age == L && !m_we && !m_g) m_rd0 <= ref_mem[m_addr[7:0]];
      if (m_age == L && !m_we && m_g) m_rd1 <= ref_mem[m_addr[7:0]];
      if (m_age == L && m_we) ref_mem[m_addr[7:0]] <= m_wdata;
      if (m_age == L + 1) m_act <= 1'b0;
    end else if (req0 || req1) begin
      m_act <= 1'b1;
      m_age <= 1;
      m_g <= pick;
      m_last <= pick;
      m_we <= pick ? we1 : we0;
      m_addr <= pick ? addr1 : addr0;
      m_wdata <= pick ? wdata1 : wdata0;
    end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("m_ack0", ack0, e_ack && !m_g);
    chk("m_ack1", ack1, e_ack && m_g);
    chk("m_rdata0", rdata0, m_rd0);
    chk("m_rdata1", rdata1, m_rd1);
    chk("m_mem_rd", mem_rd, e_acc && !m_we);
    chk("m_mem_wr", mem_wr, e_acc && m_we);
    chk("m_mem_addr", mem_addr, e_acc ? m_addr : 32'h0);
    chk("m_mem_wdata", mem_wdata, e_acc ? m_wdata : 32'h0);
    chk("m_busy", busy, m_act);
    chk("m_gnt_id", gnt_id, m_g);
    wr_cyc <= wr_cyc + (mem_wr ? 1 : 0);
    ack0_cnt <= ack0_cnt + (ack0 ? 1 : 0);
  end
  task automatic wait_ack(input int which, output int n);
    logic got;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      got = which == 0 ? ack0 : which == 1 ? ack1 : (ack0 | ack1);
    end while (!got && n < 40);
    chk("ack_seen", got, 1);
  endtask
  task automatic do_access(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    wait_ack(p ? 1 : 0, n);
    @(posedge clk); #1;
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask
  task automatic rst_pulse();
    @(posedge clk); #1 init = 1'b0;
    @(posedge clk); #1 init = 1'b1;
  endtask
  initial begin
    int n, w0, a0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rd", mem_rd, 0);
    init = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = 32'h5555_AAAA;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t1_rd", mem_rd, i < 3);
      chk("t1_ack0", ack0, i == 3);
    end
    chk("t1_rdata0", rdata0, 32'hDEADBEEF);
    chk("t1_rdata1", rdata1, 32'h0);
    @(posedge clk); #1 req0 = 1'b0;
    w0 = wr_cyc;
    a0 = ack0_cnt;
    do_access(1'b1, 1'b1, 32'h20, 32'h12345678);
    chk("t2_wr_cycles", wr_cyc - w0, 2);
    chk("t2_mem", mem[8'h20], 32'h12345678);
    do_access(1'b1, 1'b0, 32'h20, 32'hFFFF_0000);
    chk("t2_rdata1", rdata1, 32'h12345678);
    chk("t2_rdata0", rdata0, 32'hDEADBEEF);
    chk("t2_no_ack0", ack0_cnt - a0, 0);
    rst_pulse();
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h10; addr1 = 32'h30;
    for (int k = 0; k < 4; k++) begin
      wait_ack(2, n);
      chk("tie_grant", ack1, RR ? k % 2 : 0);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h30;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10;
    wait_ack(0, n);
    chk("t4_no_ack1", ack1, 0);
    @(posedge clk); #1 req0 = 1'b0;
    wait_ack(1, n);
    chk("t4_gap", n, 4);
    chk("t4_rdata1", rdata1, 32'hDEADBEEF);
    chk("t4_rdata0", rdata0, 32'hC000_0030);
    @(posedge clk); #1 req1 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(posedge clk); #1 init = 1'b0;
    #1;
    chk("t5_mem_rd", mem_rd, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ack0", ack0, 0);
    req0 = 1'b0;
    @(posedge clk); #1 init = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_ack0", ack0, 0);
      chk("t5_rdata0", rdata0, 0);
    end
    @(posedge clk); #1;
    b_req0 = 1'b1; b_addr0 = 32'h44;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rd1", b_rd, 1);
    chk("t6_ack1", b_ack0, 0);
    @(negedge clk);
    chk("t6_rd2", b_rd, 0);
    chk("t6_ack2", b_ack0, 1);
    chk("t6_rdata0", b_rdata0, 32'hA5A5_0044);
    @(posedge clk); #1 b_req0 = 1'b0;
    @(negedge clk);
    chk("t6_ack3", b_ack0, 0);
    chk("t6_busy", b_busy, 0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
